// File: rtl/chess_pkg.sv
// Shared chess types: square encoding, piece/colour codes, result codes and the start position.
package chess_pkg;

   localparam int unsigned SQ_W   = 5;
   localparam int unsigned N_SQ   = 64;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned FLAT_W = SQ_W * N_SQ;

   // bit0 occupied, bit1 colour, bits4:2 piece type
   typedef logic [SQ_W-1:0] square_t;

   localparam logic [2:0] T_PAWN   = 3'b001;
   localparam logic [2:0] T_KNIGHT = 3'b010;
   localparam logic [2:0] T_BISHOP = 3'b011;
   localparam logic [2:0] T_ROOK   = 3'b100;
   localparam logic [2:0] T_QUEEN  = 3'b101;
   localparam logic [2:0] T_KING   = 3'b110;

   localparam logic COLOR_WHITE = 1'b0;
   localparam logic COLOR_BLACK = 1'b1;

   typedef enum logic [2:0] {
      RC_OK          = 3'd0,
      RC_SRC_EMPTY   = 3'd1,
      RC_WRONG_COLOR = 3'd2,
      RC_DST_OWN     = 3'd3,
      RC_ILLEGAL     = 3'd4
   } result_code_t;

   // Row 0 is black's back rank, row 7 is white's.
   localparam square_t START_POS [0:63] = '{
      5'b10011, 5'b01011, 5'b01111, 5'b10111, 5'b11011, 5'b01111, 5'b01011, 5'b10011,
      5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00111,
      5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
      5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
      5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
      5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
      5'b00101, 5'b00101, 5'b00101, 5'b00101, 5'b00101, 5'b00101, 5'b00101, 5'b00101,
      5'b10001, 5'b01001, 5'b01101, 5'b10101, 5'b11001, 5'b01101, 5'b01001, 5'b10001
   };

   function automatic logic [IDX_W-1:0] sq_idx(input logic [2:0] row, input logic [2:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/move_checker.sv
// Combinational move validation; the first failing rule determines the result code.
module move_checker
   import chess_pkg::*;
(
   input  square_t      src_sq,
   input  square_t      dst_sq,
   input  logic         side,
   input  logic         mask_bit,
   input  logic         same_sq,
   output result_code_t code_c
);

   // Piece types play no part in validation.
   logic unused_type_bits;
   assign unused_type_bits = ^{src_sq[4:2], dst_sq[4:2]};

   always_comb begin
      code_c = RC_OK;
      if (!src_sq[0]) begin
         code_c = RC_SRC_EMPTY;
      end else if (src_sq[1] != side) begin
         code_c = RC_WRONG_COLOR;
      end else if (dst_sq[0] && (dst_sq[1] == src_sq[1])) begin
         code_c = RC_DST_OWN;
      end else if (same_sq || !mask_bit) begin
         code_c = RC_ILLEGAL;
      end
   end

endmodule

// File: rtl/board_move_executor.sv
// Holds the chess board and applies validated moves through an IDLE/CHECK/COMMIT/RESP sequence.
module board_move_executor
   import chess_pkg::*;
#(
   parameter logic [2:0] PROMOTE_TO = 3'b101,
   parameter bit         PROMOTE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              move_valid,
   output logic              move_ready,
   input  logic [IDX_W-1:0]  move_src,
   input  logic [IDX_W-1:0]  move_dst,
   input  logic [N_SQ-1:0]   move_mask,
   output logic              result_valid,
   output logic [2:0]        result_code,
   output logic [SQ_W-1:0]   captured_piece,
   output logic              side_to_move,
   output logic              game_over,
   output logic [FLAT_W-1:0] board_flat
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_COMMIT = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] src_q, src_d;
   logic [IDX_W-1:0] dst_q, dst_d;
   logic [N_SQ-1:0]  mask_q, mask_d;
   result_code_t     code_q, code_d;
   square_t          board_q [N_SQ];
   square_t          board_d [N_SQ];
   logic             side_q, side_d;
   logic             game_over_q, game_over_d;
   logic             ready_q, ready_d;
   logic             result_valid_q, result_valid_d;
   result_code_t     result_code_q, result_code_d;
   square_t          captured_q, captured_d;

   result_code_t     chk_code_c;
   square_t          moved_c;
   logic             last_rank_c;

   move_checker u_move_checker (
      .src_sq   (board_q[src_q]),
      .dst_sq   (board_q[dst_q]),
      .side     (side_q),
      .mask_bit (mask_q[dst_q]),
      .same_sq  (src_q == dst_q),
      .code_c   (chk_code_c)
   );

   // Piece as it lands on dst, including pawn promotion on the far rank.
   always_comb begin
      moved_c     = board_q[src_q];
      last_rank_c = ((moved_c[1] == COLOR_WHITE) && (dst_q[5:3] == 3'd0)) ||
                    ((moved_c[1] == COLOR_BLACK) && (dst_q[5:3] == 3'd7));
      if (PROMOTE_EN && (moved_c[4:2] == T_PAWN) && last_rank_c) begin
         moved_c[4:2] = PROMOTE_TO;
      end
   end

   always_comb begin
      state_d        = state_q;
      src_d          = src_q;
      dst_d          = dst_q;
      mask_d         = mask_q;
      code_d         = code_q;
      board_d        = board_q;
      side_d         = side_q;
      game_over_d    = game_over_q;
      result_valid_d = 1'b0;
      result_code_d  = result_code_q;
      captured_d     = captured_q;

      case (state_q)
         S_IDLE: begin
            if (move_valid && ready_q) begin
               src_d   = move_src;
               dst_d   = move_dst;
               mask_d  = move_mask;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            code_d  = chk_code_c;
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            if (code_q == RC_OK) begin
               board_d[dst_q] = moved_c;
               board_d[src_q] = '0;
               side_d         = ~side_q;
               captured_d     = board_q[dst_q];
               if (board_q[dst_q][4:2] == T_KING) begin
                  game_over_d = 1'b1;
               end
            end else begin
               captured_d = '0;
            end
            result_code_d  = code_q;
            result_valid_d = 1'b1;
            state_d        = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE) && !game_over_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         src_q          <= '0;
         dst_q          <= '0;
         mask_q         <= '0;
         code_q         <= RC_OK;
         board_q        <= START_POS;
         side_q         <= 1'b0;
         game_over_q    <= 1'b0;
         ready_q        <= 1'b1;
         result_valid_q <= 1'b0;
         result_code_q  <= RC_OK;
         captured_q     <= '0;
      end else begin
         state_q        <= state_d;
         src_q          <= src_d;
         dst_q          <= dst_d;
         mask_q         <= mask_d;
         code_q         <= code_d;
         board_q        <= board_d;
         side_q         <= side_d;
         game_over_q    <= game_over_d;
         ready_q        <= ready_d;
         result_valid_q <= result_valid_d;
         result_code_q  <= result_code_d;
         captured_q     <= captured_d;
      end
   end

   always_comb begin
      board_flat = '0;
      for (int i = 0; i < int'(N_SQ); i++) begin
         board_flat[SQ_W*i +: SQ_W] = board_q[i];
      end
   end

   assign move_ready     = ready_q;
   assign result_valid   = result_valid_q;
   assign result_code    = 3'(result_code_q);
   assign captured_piece = captured_q;
   assign side_to_move   = side_q;
   assign game_over      = game_over_q;

endmodule

// File: tb/tb_board_move_executor.sv
// Scoreboard bench for board_move_executor: a reference board model predicts results and board contents.
module tb_board_move_executor;
   import chess_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         move_valid;
   logic         move_ready;
   logic [5:0]   move_src;
   logic [5:0]   move_dst;
   logic [63:0]  move_mask;
   logic         result_valid;
   logic [2:0]   result_code;
   logic [4:0]   captured_piece;
   logic         side_to_move;
   logic         game_over;
   logic [319:0] board_flat;

   board_move_executor dut (
      .clk            (clk),
      .reset          (reset),
      .move_valid     (move_valid),
      .move_ready     (move_ready),
      .move_src       (move_src),
      .move_dst       (move_dst),
      .move_mask      (move_mask),
      .result_valid   (result_valid),
      .result_code    (result_code),
      .captured_piece (captured_piece),
      .side_to_move   (side_to_move),
      .game_over      (game_over),
      .board_flat     (board_flat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] code;
      logic [4:0] cap;
   } exp_t;
   exp_t sb[$];

   logic [4:0] mb [64];
   logic       m_side;
   logic       m_go;
   localparam logic [63:0] ALL = '1;

   task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 320'(1), 320'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_code", 320'(result_code), 320'(e.code));
            chk("captured", 320'(captured_piece), 320'(e.cap));
         end
      end
   end

   task automatic model_reset();
      logic [4:0] r0 [8];
      logic [4:0] r7 [8];
      r0 = '{5'b10011, 5'b01011, 5'b01111, 5'b10111, 5'b11011, 5'b01111, 5'b01011, 5'b10011};
      r7 = '{5'b10001, 5'b01001, 5'b01101, 5'b10101, 5'b11001, 5'b01101, 5'b01001, 5'b10001};
      for (int i = 0; i < 64; i++) mb[i] = 5'b0;
      for (int c = 0; c < 8; c++) begin
         mb[c]      = r0[c];
         mb[8 + c]  = 5'b00111;
         mb[48 + c] = 5'b00101;
         mb[56 + c] = r7[c];
      end
      m_side = 1'b0;
      m_go   = 1'b0;
   endtask

   function automatic logic [319:0] model_flat();
      logic [319:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[5*i +: 5] = mb[i];
      return r;
   endfunction

   task automatic apply_reset();
      reset      = 1'b1;
      move_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_move(input int src, input int dst, input logic [63:0] mask, input logic [2:0] ecode);
      int         n;
      logic       got;
      logic [4:0] cap;
      logic [4:0] pc;
      n = 0;
      while (!move_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_move", 320'(move_ready), 320'(1));
      cap = (ecode == 3'd0) ? mb[dst] : 5'b0;
      sb.push_back('{ecode, cap});
      move_src   = 6'(src);
      move_dst   = 6'(dst);
      move_mask  = mask;
      move_valid = 1'b1;
      @(posedge clk);
      #1;
      // Scramble request fields after accept; the DUT must use the latched copies.
      move_valid = 1'b0;
      move_src   = 6'($urandom);
      move_dst   = 6'($urandom);
      move_mask  = {$urandom, $urandom};
      n   = 0;
      got = 1'b0;
      while (!got && n < 8) begin
         @(negedge clk);
         n++;
         got = result_valid;
      end
      chk("latency", 320'(n), 320'(3));
      if (ecode == 3'd0) begin
         pc = mb[src];
         if (pc[4:2] == 3'b001 && ((pc[1] == 1'b0 && dst / 8 == 0) || (pc[1] == 1'b1 && dst / 8 == 7)))
            pc[4:2] = 3'b101;
         if (mb[dst][4:2] == 3'b110) m_go = 1'b1;
         mb[dst] = pc;
         mb[src] = 5'b0;
         m_side  = ~m_side;
      end
      chk("board", board_flat, model_flat());
      chk("side", 320'(side_to_move), 320'(m_side));
      chk("game_over", 320'(game_over), 320'(m_go));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      move_valid = 1'b0;
      move_src   = '0;
      move_dst   = '0;
      move_mask  = '0;
      apply_reset();

      chk("rst_sq60", 320'(board_flat[304:300]), 320'(5'b11001));
      chk("rst_sq4", 320'(board_flat[24:20]), 320'(5'b11011));
      chk("rst_sq36", 320'(board_flat[184:180]), 320'(0));
      chk("rst_side", 320'(side_to_move), 320'(0));
      chk("rst_ready", 320'(move_ready), 320'(1));
      chk("rst_rvalid", 320'(result_valid), 320'(0));
      chk("rst_gover", 320'(game_over), 320'(0));
      chk("rst_code", 320'(result_code), 320'(0));
      chk("rst_cap", 320'(captured_piece), 320'(0));
      chk("rst_board", board_flat, model_flat());

      do_move(52, 36, 64'(1) << 36, 3'd0);
      chk("e4_sq36", 320'(board_flat[184:180]), 320'(5'b00101));
      chk("e4_sq52", 320'(board_flat[264:260]), 320'(0));
      chk("e4_side", 320'(side_to_move), 320'(1));

      do_move(51, 35, 64'(1) << 35, 3'd2);
      do_move(35, 27, ALL, 3'd1);
      do_move(1, 11, ALL, 3'd3);
      // A same-square request lands on the mover's own piece, so DST_OWN wins.
      do_move(12, 12, ALL, 3'd3);
      do_move(12, 20, ~(64'(1) << 20), 3'd4);

      do_move(15, 23, ALL, 3'd0);
      do_move(48, 8, ALL, 3'd0);
      chk("cap_48_8", 320'(captured_piece), 320'(5'b00111));
      do_move(9, 17, ALL, 3'd0);
      do_move(8, 0, ALL, 3'd0);
      chk("promo_sq0", 320'(board_flat[4:0]), 320'(5'b10101));
      chk("promo_cap", 320'(captured_piece), 320'(5'b10011));
      do_move(14, 22, ALL, 3'd0);
      do_move(sq_idx(3'd7, 3'd3), sq_idx(3'd0, 3'd4), ALL, 3'd0);
      chk("king_cap", 320'(captured_piece), 320'(5'b11011));
      chk("king_gover", 320'(game_over), 320'(1));

      // After game over, requests must be refused with no result.
      move_src   = 6'd52;
      move_dst   = 6'd44;
      move_mask  = ALL;
      move_valid = 1'b1;
      repeat (8) @(negedge clk);
      chk("gover_ready", 320'(move_ready), 320'(0));
      move_valid = 1'b0;
      chk("gover_board", board_flat, model_flat());

      apply_reset();
      chk("rst2_board", board_flat, model_flat());
      chk("rst2_gover", 320'(game_over), 320'(0));
      chk("rst2_ready", 320'(move_ready), 320'(1));

      // Reset lands on the COMMIT edge of an in-flight move.
      move_src   = 6'd52;
      move_dst   = 6'd36;
      move_mask  = ALL;
      move_valid = 1'b1;
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (6) begin
         @(negedge clk);
         chk("midrst_no_result", 320'(result_valid), 320'(0));
      end
      chk("midrst_board", board_flat, model_flat());
      chk("midrst_side", 320'(side_to_move), 320'(0));
      chk("midrst_ready", 320'(move_ready), 320'(1));

      do_move(52, 36, 64'(1) << 36, 3'd0);
      repeat (3) @(negedge clk);
      chk("sb_empty", 320'(sb.size()), 320'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
